// File: rtl/pc_pkg.sv
// Shared types and program-specific constants for the next-PC sequencer.
// JUMP_TGT is edited per program; entry 3 must stay 12'h123.
package pc_pkg;

   localparam int PC_D = 12;
   localparam int PC_O = 8;
   localparam int PC_L = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_t;

   localparam logic [PC_D-1:0] JUMP_TGT [2**PC_L] = '{
      12'h000, 12'h040, 12'h080, 12'h123,
      12'h200, 12'h2A5, 12'h3FF, 12'h400,
      12'h555, 12'h7FE, 12'h800, 12'h9AB,
      12'hABC, 12'hC00, 12'hDEF, 12'hFFF
   };

endpackage

// File: rtl/jump_lut.sv
// Combinational ROM of absolute jump targets.
// The table contents come from pc_pkg::JUMP_TGT.
module jump_lut
   import pc_pkg::*;
#(
   parameter int D = PC_D,
   parameter int L = PC_L
) (
   input  logic [L-1:0] lut_idx,
   output logic [D-1:0] tgt
);

   assign tgt = D'(JUMP_TGT[lut_idx]);

endmodule

// File: rtl/next_pc_ctrl.sv
// Next-PC sequencer: run-control FSM, RUN cycle counter and next-PC mux.
// It feeds the PC register's input; the PC itself adds the one-cycle latency.
//
// state | meaning
// IDLE  | waiting for start, PC held
// RUN   | program executing, cycle_ct counting
// HALT  | halt retired, done high, PC and cycle_ct frozen
module next_pc_ctrl
   import pc_pkg::*;
#(
   parameter int D = PC_D,
   parameter int O = PC_O,
   parameter int L = PC_L
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [D-1:0] start_addr,
   input  logic [D-1:0] pc_cur,
   input  logic         reljump_en,
   input  logic         absjump_en,
   input  logic [O-1:0] rel_offset,
   input  logic [L-1:0] lut_idx,
   input  logic         stall,
   input  logic         halt,
   output logic [D-1:0] pc_next,
   output logic         running,
   output logic         done,
   output logic [31:0]  cycle_ct
);

   pc_state_t    state;
   logic [D-1:0] lut_tgt;
   logic [D-1:0] rel_sum;
   logic [D-1:0] inc_sum;

   jump_lut #(.D(D), .L(L)) u_jump_lut (
      .lut_idx (lut_idx),
      .tgt     (lut_tgt)
   );

   // Both sums wrap modulo 2^D by truncation to D bits.
   assign rel_sum = pc_cur + {{(D-O){rel_offset[O-1]}}, rel_offset};
   assign inc_sum = pc_cur + D'(1);

   always_comb begin
      pc_next = pc_cur;
      if (reset) begin
         pc_next = '0;
      end else begin
         case (state)
            IDLE: if (start) pc_next = start_addr;
            RUN: begin
               if (halt || stall)   pc_next = pc_cur;
               else if (absjump_en) pc_next = lut_tgt;
               else if (reljump_en) pc_next = rel_sum;
               else                 pc_next = inc_sum;
            end
            HALT: if (start) pc_next = start_addr;
            default: pc_next = pc_cur;
         endcase
      end
   end

   assign running = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         done     <= 1'b0;
         cycle_ct <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  cycle_ct <= '0;
               end
            end
            RUN: begin
               // The halt cycle itself is counted; the counter saturates.
               if (cycle_ct != 32'hFFFF_FFFF) cycle_ct <= cycle_ct + 32'd1;
               if (halt) begin
                  state <= HALT;
                  done  <= 1'b1;
               end
            end
            HALT: begin
               if (start) begin
                  state    <= RUN;
                  done     <= 1'b0;
                  cycle_ct <= '0;
               end
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
